// File: rtl/rf_multiport_sb.sv
// Parametrised multi-read-port register file with write-to-read bypass and a
// per-register busy scoreboard used by decode for pipeline hazard detection.
module rf_multiport_sb #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     iss_en,
    input  logic [AW-1:0]            iss_addr,
    output logic [AW:0]              busy_cnt
);

    localparam logic [AW:0] DEPTH_V = DEPTH[AW:0];

    logic [DATA_W-1:0] regs_r [DEPTH];
    logic [DEPTH-1:0]  busy_r;
    logic [DEPTH-1:0]  busy_nxt_s;
    logic [AW:0]       busy_cnt_r;
    logic              wr_valid_s;
    logic              iss_valid_s;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_V);
    endfunction

    function automatic logic is_zero_reg(input logic [AW-1:0] a);
        return ZERO_REG && (a == {AW{1'b0}});
    endfunction

    function automatic logic [AW:0] popcount(input logic [DEPTH-1:0] v);
        logic [AW:0] cnt;
        cnt = {(AW+1){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + {{AW{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    // Write and issue qualifiers; gating with rst_n also suppresses the bypass during reset
    always_comb begin
        wr_valid_s  = rst_n && wr_en  && addr_ok(wr_addr)  && !is_zero_reg(wr_addr);
        iss_valid_s = rst_n && iss_en && addr_ok(iss_addr) && !is_zero_reg(iss_addr);
    end

    // Next scoreboard state: a new issue wins over a retiring writeback to the same register
    always_comb begin
        busy_nxt_s = busy_r;
        for (int i = 0; i < DEPTH; i++) begin
            busy_nxt_s[i] = (iss_valid_s && (iss_addr == AW'(i))) ||
                            (busy_r[i] && !(wr_valid_s && (wr_addr == AW'(i))));
        end
    end

    // Register array write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_valid_s) begin
            regs_r[wr_addr] <= wr_data;
        end
    end

    // Scoreboard bits and their registered population count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r     <= {DEPTH{1'b0}};
            busy_cnt_r <= {(AW+1){1'b0}};
        end else begin
            busy_r     <= busy_nxt_s;
            busy_cnt_r <= popcount(busy_nxt_s);
        end
    end

    assign busy_cnt = busy_cnt_r;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [AW-1:0]     addr_s;
        logic [DATA_W-1:0] data_s;
        logic              busy_s;

        assign addr_s = rd_addr[g*AW +: AW];

        // Read resolution: out of range, zero register, bypass, then array
        always_comb begin
            data_s = {DATA_W{1'b0}};
            busy_s = 1'b0;
            if (!addr_ok(addr_s)) begin
                data_s = {DATA_W{1'b0}};
                busy_s = 1'b0;
            end else if (is_zero_reg(addr_s)) begin
                data_s = {DATA_W{1'b0}};
                busy_s = 1'b0;
            end else if (BYPASS && wr_valid_s && (wr_addr == addr_s)) begin
                data_s = wr_data;
                busy_s = iss_valid_s && (iss_addr == addr_s);
            end else begin
                data_s = regs_r[addr_s];
                busy_s = busy_r[addr_s];
            end
        end

        assign rd_data[g*DATA_W +: DATA_W] = data_s;
        assign rd_busy[g]                  = busy_s;
    end

endmodule

// File: doc/rf_multiport_sb.md
Name: rf_multiport_sb

Overview:
- Parametrised general-purpose register file for the single-cycle and pipelined CPU datapaths.
- Generalises the 32x32 two-read/one-write register file in four ways:
  - configurable width, depth and read-port count;
  - optional hardwired zero register;
  - optional write-to-read bypass;
  - per-register busy scoreboard for pipeline hazard detection.
- Sits between decode (read ports, issue) and writeback (write port).

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of registers (2..64, need not be a power of two).
- NUM_RD, 2, number of independent read ports (1..4).
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/issue.
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports.
- Local: AW = $clog2(DEPTH).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous reset, active low.
- rd_addr  in  NUM_RD*AW  packed read addresses; port i = bits [i*AW +: AW].
- rd_data  out  NUM_RD*DATA_W  packed read data, combinational.
- rd_busy  out  NUM_RD  scoreboard bit of the addressed register, combinational.
- wr_en  in  1  writeback strobe.
- wr_addr  in  AW  writeback register index.
- wr_data  in  DATA_W  writeback data.
- iss_en  in  1  issue strobe: mark iss_addr as having an in-flight producer.
- iss_addr  in  AW  destination register of the issued instruction.
- busy_cnt  out  AW+1  number of registers currently marked busy, registered.

Behaviour:
- Reset (rst_n=0, asynchronous, independent of clk):
  - all DEPTH registers = 0;
  - all busy bits = 0;
  - busy_cnt = 0.
  - Assertion mid-cycle clears state immediately.
  - While rst_n=0, writes and issues are ignored.
- Write:
  - on rising clk with wr_en=1 and a valid address, R[wr_addr] <= wr_data;
  - new value visible on the non-bypassed read path from the following cycle.
- Read: rd_data[i] is combinational from rd_addr[i], resolved in this priority order:
  - (a) address >= DEPTH returns 0;
  - (b) ZERO_REG=1 and address 0 returns 0;
  - (c) BYPASS=1, wr_en=1, wr_addr == rd_addr[i] and wr_addr valid returns wr_data (zero latency);
  - (d) otherwise R[rd_addr[i]].
- Invalid addresses: wr_addr/iss_addr >= DEPTH are ignored (no state change). With ZERO_REG=1, any write or issue to index 0 is ignored.
- Scoreboard: per-register busy bit, updated on rising clk:
  - iss_en to a valid address: busy <= 1.
  - wr_en to a valid address: busy <= 0.
  - Both to the same register in the same cycle: busy <= 1 (a new producer supersedes the retiring one); the data write still occurs.
  - Both to different registers: both updates apply.
  - Issue to an already-busy register: stays 1, no error.
  - Write to a non-busy register: data written, busy stays 0.
- rd_busy[i]:
  - reflects the current busy bit of rd_addr[i];
  - is 0 for invalid addresses and for register 0 when ZERO_REG=1;
  - when BYPASS=1 and the same-cycle writeback matches, shows 0 unless iss_en also targets that register this cycle (decode may consume the bypassed value).
- busy_cnt:
  - equals the population count of the busy bits after each edge;
  - maximum DEPTH (or DEPTH-1 when ZERO_REG=1);
  - never wraps.
- All NUM_RD ports are fully independent; any number may address the same register.

Test Plan:
- Reset then read: pulse rst_n low mid-cycle after writing R5=0xDEADBEEF, read port0 addr 5 -> rd_data=0, rd_busy=0, busy_cnt=0 immediately, without a clock edge.
- Write/read plus zero register:
  - write R3=0x12345678, next cycle ports 0/1 read 3/3 -> both 0x12345678;
  - write R0=0xFFFFFFFF with ZERO_REG=1 -> R0 reads 0.
- Bypass: same cycle wr_en=1, wr_addr=7, wr_data=0xA5A5A5A5, rd_addr port1=7 -> rd_data port1=0xA5A5A5A5 before the edge; with BYPASS=0 -> old value 0 until after the edge.
- Scoreboard lifecycle:
  - issue R9 -> rd_busy=1, busy_cnt=1;
  - issue R10 -> busy_cnt=2;
  - writeback R9 -> busy_cnt=1, R9 not busy;
  - simultaneous issue R10 and writeback R10 -> R10 stays busy, data updated, busy_cnt=1.
- Boundaries with DEPTH=20:
  - write/issue to index 25 -> no state change, busy_cnt unchanged, read of 25 -> 0;
  - issue all 19 valid non-zero registers -> busy_cnt=19;
  - NUM_RD=4 with all ports on R19 -> identical data.
